// File: rtl/exhaustive_vector_checker.sv
// Exhaustive truth-table checker: walks all 2^N_IN vectors (binary or Gray order),
// holds each for SETTLE cycles, samples dut_x and scores it against EXPECT.
module exhaustive_vector_checker #(
  parameter int unsigned          N_IN   = 3,
  parameter int unsigned          SETTLE = 1,
  parameter int unsigned          MODE   = 0,
  parameter logic [(1<<N_IN)-1:0] EXPECT = 8'hE8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            dut_x,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_err_vec,
  output logic            mon_valid,
  output logic [N_IN-1:0] mon_vec,
  output logic            mon_x,
  output logic            mon_err
);

  localparam int unsigned   CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t          state_q, state_d;
  logic [N_IN-1:0] idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic [N_IN:0]   err_q, err_d;
  logic [N_IN-1:0] ferr_q, ferr_d;
  logic            mv_q, mv_d;
  logic [N_IN-1:0] mvec_q, mvec_d;
  logic            mx_q, mx_d;
  logic            merr_q, merr_d;
  logic            mismatch;

  function automatic logic [N_IN-1:0] map_vec(input logic [N_IN-1:0] i);
    if (MODE == 1) return i ^ (i >> 1);
    else           return i;
  endfunction

  // Expected value is looked up by the driven vector, not by the walk index.
  assign mismatch = (dut_x != EXPECT[stim_q]);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    err_d   = err_q;
    ferr_d  = ferr_q;
    mv_d    = 1'b0;
    mvec_d  = mvec_q;
    mx_d    = mx_q;
    merr_d  = merr_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = HOLD;
          idx_d   = '0;
          cnt_d   = '0;
          stim_d  = map_vec('0);
          err_d   = '0;
          ferr_d  = '0;
        end
      end
      HOLD: begin
        if (cnt_q != CNT_LAST) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          mv_d   = 1'b1;
          mvec_d = stim_q;
          mx_d   = dut_x;
          merr_d = mismatch;
          if (mismatch) begin
            err_d = err_q + 1'b1;
            if (err_q == '0) ferr_d = stim_q;
          end
          if (idx_q == '1) begin
            state_d = DONE;
          end else begin
            idx_d  = idx_q + 1'b1;
            stim_d = map_vec(idx_q + 1'b1);
            cnt_d  = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      stim_q  <= '0;
      err_q   <= '0;
      ferr_q  <= '0;
      mv_q    <= 1'b0;
      mvec_q  <= '0;
      mx_q    <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
      mv_q    <= mv_d;
      mvec_q  <= mvec_d;
      mx_q    <= mx_d;
      merr_q  <= merr_d;
    end
  end

  assign stim          = stim_q;
  assign busy          = (state_q == HOLD);
  assign done          = (state_q == DONE);
  assign pass          = done & (err_q == '0);
  assign err_count     = err_q;
  assign first_err_vec = ferr_q;
  assign mon_valid     = mv_q;
  assign mon_vec       = mvec_q;
  assign mon_x         = mx_q;
  assign mon_err       = merr_q;

endmodule

// File: tb/tb_exhaustive_vector_checker.sv
// Directed bench: three checker instances (binary/SETTLE=1, Gray, SETTLE=3) each
// beside a majority-gate model whose output can be inverted per vector.
module tb_exhaustive_vector_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start         [3];
  logic [2:0] stim          [3];
  logic       dut_x         [3];
  logic       busy          [3];
  logic       done          [3];
  logic       pass          [3];
  logic [3:0] err_count     [3];
  logic [2:0] first_err_vec [3];
  logic       mon_valid     [3];
  logic [2:0] mon_vec       [3];
  logic       mon_x         [3];
  logic       mon_err       [3];
  logic [7:0] fault         [3];

  int checks = 0;
  int errors = 0;

  logic [2:0] bin_seq  [8];
  logic [2:0] gray_seq [8];

  typedef struct {
    logic [7:0] fault;
    int         exp_err;
    int         exp_first;
    int         exp_pass;
    int         poke;
  } vec_t;

  vec_t tbl [7];

  always #5 clk = ~clk;

  function automatic logic maj(input logic [2:0] v);
    return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign dut_x[g] = maj(stim[g]) ^ fault[g][stim[g]];
  end

  exhaustive_vector_checker #(.N_IN(3), .SETTLE(1), .MODE(0), .EXPECT(8'hE8)) u_bin (
    .clk(clk), .reset(reset), .start(start[0]), .stim(stim[0]), .dut_x(dut_x[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_count(err_count[0]),
    .first_err_vec(first_err_vec[0]), .mon_valid(mon_valid[0]), .mon_vec(mon_vec[0]),
    .mon_x(mon_x[0]), .mon_err(mon_err[0]));

  exhaustive_vector_checker #(.N_IN(3), .SETTLE(1), .MODE(1), .EXPECT(8'hE8)) u_gray (
    .clk(clk), .reset(reset), .start(start[1]), .stim(stim[1]), .dut_x(dut_x[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_count(err_count[1]),
    .first_err_vec(first_err_vec[1]), .mon_valid(mon_valid[1]), .mon_vec(mon_vec[1]),
    .mon_x(mon_x[1]), .mon_err(mon_err[1]));

  exhaustive_vector_checker #(.N_IN(3), .SETTLE(3), .MODE(0), .EXPECT(8'hE8)) u_slow (
    .clk(clk), .reset(reset), .start(start[2]), .stim(stim[2]), .dut_x(dut_x[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_count(err_count[2]),
    .first_err_vec(first_err_vec[2]), .mon_valid(mon_valid[2]), .mon_vec(mon_vec[2]),
    .mon_x(mon_x[2]), .mon_err(mon_err[2]));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_idle_zero(input int u, input string tag);
    chk($sformatf("%s u%0d stim", tag, u), int'(stim[u]), 0);
    chk($sformatf("%s u%0d busy", tag, u), int'(busy[u]), 0);
    chk($sformatf("%s u%0d done", tag, u), int'(done[u]), 0);
    chk($sformatf("%s u%0d pass", tag, u), int'(pass[u]), 0);
    chk($sformatf("%s u%0d err_count", tag, u), int'(err_count[u]), 0);
    chk($sformatf("%s u%0d first_err", tag, u), int'(first_err_vec[u]), 0);
    chk($sformatf("%s u%0d mon_valid", tag, u), int'(mon_valid[u]), 0);
    chk($sformatf("%s u%0d mon_vec", tag, u), int'(mon_vec[u]), 0);
    chk($sformatf("%s u%0d mon_x", tag, u), int'(mon_x[u]), 0);
    chk($sformatf("%s u%0d mon_err", tag, u), int'(mon_err[u]), 0);
  endtask

  task automatic pulse_start(input int u);
    @(negedge clk);
    start[u] = 1'b1;
    @(posedge clk);
    #1;
    start[u] = 1'b0;
  endtask

  // Full run: starts on unit u, checks every cycle of the walk and the final status.
  task automatic run(input int u, input int settle, input int gray, input logic [7:0] f,
                     input int exp_err, input int exp_first, input int exp_pass, input int poke);
    logic [2:0] v;
    logic [2:0] prev;
    fault[u] = f;
    pulse_start(u);
    chk($sformatf("u%0d accept done", u), int'(done[u]), 0);
    chk($sformatf("u%0d accept err_count", u), int'(err_count[u]), 0);
    chk($sformatf("u%0d accept first_err", u), int'(first_err_vec[u]), 0);
    prev = '0;
    for (int j = 0; j < 8; j++) begin
      v = (gray != 0) ? gray_seq[j] : bin_seq[j];
      for (int c = 0; c < settle; c++) begin
        start[u] = (j == poke && c == 0);
        chk($sformatf("u%0d v%0d c%0d stim", u, j, c), int'(stim[u]), int'(v));
        chk($sformatf("u%0d v%0d c%0d busy", u, j, c), int'(busy[u]), 1);
        chk($sformatf("u%0d v%0d c%0d done", u, j, c), int'(done[u]), 0);
        if (c == 0 && j > 0) begin
          chk($sformatf("u%0d v%0d mon_valid", u, j), int'(mon_valid[u]), 1);
          chk($sformatf("u%0d v%0d mon_vec", u, j), int'(mon_vec[u]), int'(prev));
          chk($sformatf("u%0d v%0d mon_x", u, j), int'(mon_x[u]), int'(maj(prev) ^ f[prev]));
          chk($sformatf("u%0d v%0d mon_err", u, j), int'(mon_err[u]), int'(f[prev]));
        end else begin
          chk($sformatf("u%0d v%0d c%0d mon_valid idle", u, j, c), int'(mon_valid[u]), 0);
        end
        @(posedge clk);
        #1;
      end
      prev = v;
    end
    start[u] = 1'b0;
    chk($sformatf("u%0d end mon_valid", u), int'(mon_valid[u]), 1);
    chk($sformatf("u%0d end mon_vec", u), int'(mon_vec[u]), int'(prev));
    chk($sformatf("u%0d end mon_err", u), int'(mon_err[u]), int'(f[prev]));
    chk($sformatf("u%0d end stim", u), int'(stim[u]), int'(prev));
    chk($sformatf("u%0d end done", u), int'(done[u]), 1);
    chk($sformatf("u%0d end busy", u), int'(busy[u]), 0);
    chk($sformatf("u%0d end pass", u), int'(pass[u]), exp_pass);
    chk($sformatf("u%0d end err_count", u), int'(err_count[u]), exp_err);
    chk($sformatf("u%0d end first_err", u), int'(first_err_vec[u]), exp_first);
    @(posedge clk);
    #1;
    chk($sformatf("u%0d done held", u), int'(done[u]), 1);
    chk($sformatf("u%0d mon_valid single", u), int'(mon_valid[u]), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bin_seq  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    gray_seq = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
    //            fault   err first pass poke
    tbl[0] = '{8'h00, 0, 0, 1, -1};
    tbl[1] = '{8'h60, 2, 5, 0, -1};
    tbl[2] = '{8'h00, 0, 0, 1,  3};
    tbl[3] = '{8'h01, 1, 0, 0, -1};
    tbl[4] = '{8'h80, 1, 7, 0, -1};
    tbl[5] = '{8'hFF, 8, 0, 0, -1};
    tbl[6] = '{8'h24, 2, 2, 0, -1};

    reset = 1'b1;
    for (int u = 0; u < 3; u++) begin
      start[u] = 1'b0;
      fault[u] = 8'h00;
    end
    #12;
    for (int u = 0; u < 3; u++) chk_idle_zero(u, "reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("idle no start busy", int'(busy[0]), 0);

    // Back-to-back runs: every run after the first restarts from DONE.
    for (int i = 0; i < 7; i++)
      run(0, 1, 0, tbl[i].fault, tbl[i].exp_err, tbl[i].exp_first, tbl[i].exp_pass, tbl[i].poke);

    run(1, 1, 1, 8'h00, 0, 0, 1, -1);
    run(1, 1, 1, 8'h30, 2, 5, 0, -1);
    run(2, 3, 0, 8'h00, 0, 0, 1, -1);
    run(2, 3, 0, 8'h08, 1, 3, 0, -1);

    // Asynchronous reset mid-cycle while vector 4 is driven.
    fault[0] = 8'h01;
    pulse_start(0);
    n = 0;
    while (stim[0] !== 3'd4 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach vec4 within bound", int'(n < 20), 1);
    chk("pre-reset err_count", int'(err_count[0]), 1);
    #2;
    reset = 1'b1;
    #1;
    for (int u = 0; u < 3; u++) chk_idle_zero(u, "async reset");
    #3;
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("post-reset stim", int'(stim[0]), 0);
      chk("post-reset busy", int'(busy[0]), 0);
      chk("post-reset done", int'(done[0]), 0);
      chk("post-reset mon_valid", int'(mon_valid[0]), 0);
    end
    run(0, 1, 0, 8'h00, 0, 0, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exhaustive_vector_checker.md
# exhaustive_vector_checker

Synthesizable, parametrised exhaustive truth-table checker for small combinational blocks under test. It walks every input vector of an N_IN-input DUT in binary or Gray order, holds each vector for a programmable settle time and samples the DUT's single output. It compares the sample against a parameter truth table and reports per-vector monitor beats, an error count, the first failing vector and a pass flag. It sits beside the DUT in lab top-levels and replaces simulation-only stimulus loops and print-based monitoring with hardware that can also run on the board.

## Interface
- N_IN, default 3: number of DUT inputs; vector space is 2^N_IN (supported 1..8).
- SETTLE, default 1: clock cycles each vector is held; must be ≥1.
- MODE, default 0: vector order; 0 = ascending binary, 1 = reflected Gray (i ^ (i>>1)).
- EXPECT, default 8'hE8 (3-input majority): 2^N_IN-bit truth table; bit v is the expected DUT output for stim == v.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request a run; sampled only in IDLE or DONE.
- stim  out  N_IN  DUT input vector; stim[N_IN-1] is the MSB (a in {a,b,c}).
- dut_x  in  1  DUT output, combinational from stim.
- busy  out  1  high while a run is in progress.
- done  out  1  level; high from run completion until the next accepted start or reset.
- pass  out  1  valid while done; 1 iff err_count == 0.
- err_count  out  N_IN+1  number of mismatching vectors in the current/last run.
- first_err_vec  out  N_IN  stim value of the first mismatch; 0 if none.
- mon_valid  out  1  one-cycle pulse per sampled vector.
- mon_vec  out  N_IN  vector sampled; valid with mon_valid.
- mon_x  out  1  sampled dut_x; valid with mon_valid.
- mon_err  out  1  1 if the sample mismatched EXPECT; valid with mon_valid.

## Operation
- States: IDLE, HOLD, DONE.
- Reset value of every output is 0. State returns to IDLE and the index and settle counters clear.
- IDLE/DONE with start=1: clear err_count, first_err_vec and done. Set index=0, cnt=0, stim=map(0). Go to HOLD with busy=1.
- HOLD, cnt < SETTLE-1: cnt increments; stim is held.
- HOLD, cnt == SETTLE-1 (sample edge):
  - Capture dut_x and compare it with EXPECT[stim].
  - On mismatch, increment err_count. If this is the first mismatch (err_count was 0), latch first_err_vec=stim.
  - Register mon_vec=stim, mon_x=dut_x, mon_err, and pulse mon_valid.
  - If index == 2^N_IN-1: go to DONE with busy=0 and done=1. stim holds the last vector.
  - Otherwise: index+1, stim=map(index+1), cnt=0.
- map(i) = i when MODE=0, and i ^ (i>>1) when MODE=1. Expected value is always indexed by the actual stim value, not by the index.
- start while in HOLD is ignored.
- start in DONE restarts immediately. done drops on the accept edge.
- err_count cannot overflow: its width N_IN+1 holds 2^N_IN.
- pass = done & (err_count == 0). It is combinational from registered state.

## Timing
- Start accepted on edge k: stim=map(0) and busy=1 after edge k.
- Each vector is driven for exactly SETTLE cycles. The sample is taken on the last edge of that window.
- mon_valid for vector j is high in the cycle after its sample edge. It coincides with the first cycle of vector j+1, or with the first DONE cycle for the last vector.
- Total run time: done=1 after edge k + 2^N_IN·SETTLE. Defaults give 8 cycles.
- err_count and first_err_vec update on the sample edge, together with the mon_* registers.
- Asynchronous reset mid-run forces all outputs to 0 without a clock. The run is abandoned; no partial done is produced.

## Test plan
- Defaults, DUT = majority(a,b,c), start pulsed once: stim steps 0..7, one per cycle. Eight mon_valid pulses with mon_err=0. done=1 eight cycles after start; pass=1, err_count=0.
- Same setup, DUT output forced inverted only when stim==5 and stim==6: err_count=2, first_err_vec=5, pass=0. mon_err is 1 exactly on the beats with mon_vec 5 and 6.
- MODE=1: stim sequence is 0,1,3,2,6,7,5,4. With a correct DUT, pass=1; each mon_vec matches that sequence.
- SETTLE=3: each stim value is stable 3 cycles, mon_valid has a 3-cycle period, and done rises at start+24.
- start re-pulsed during HOLD at vector 3: it is ignored, the sequence continues unchanged, and done arrives at start+8. start in DONE clears done and err_count and reruns.
- reset asserted asynchronously mid-cycle while stim==4: all outputs go to 0 immediately. After release there is no activity until start; the next run begins at vector 0.
